// File: rtl/sample_hold_sched.sv
// Round-robin scheduler sharing one sample-and-hold capture stage between N_REQ requesters.
// Optional autonomous refresh captures are enabled by defining SAMPLE_HOLD_SCHED_AUTO_EN.
module sample_hold_sched #(
    parameter int N_REQ       = 4,
    parameter int CAPTURE_LAT = 2,
    parameter int HOLD        = 4,
`ifdef SAMPLE_HOLD_SCHED_AUTO_EN
    parameter int REFRESH     = 64,
`endif
    localparam int SEL_BITS   = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [N_REQ-1:0]    req,
    output logic [N_REQ-1:0]    ack,
    output logic                sh_sync,
    output logic [SEL_BITS-1:0] sel,
    output logic                busy
);

    localparam int CNT_MAX = (CAPTURE_LAT > HOLD) ? CAPTURE_LAT : HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SEL_BITS-1:0] sel_q, sel_d;
    logic [SEL_BITS-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                sh_sync_q, sh_sync_d;
    logic                busy_q, busy_d;
    logic                refresh_q, refresh_d;
    logic                start_refresh_s;

    // First set request bit at or above the pointer, wrapping modulo N_REQ.
    function automatic logic [SEL_BITS-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                    input logic [SEL_BITS-1:0] p);
        logic [SEL_BITS-1:0] w;
        logic                found;
        int                  idx;
        w     = p;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(p) + i) % N_REQ;
            if (!found && r[idx]) begin
                w     = SEL_BITS'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return w;
    endfunction

`ifdef SAMPLE_HOLD_SCHED_AUTO_EN
    localparam int IDLE_W = $clog2(REFRESH);

    logic [IDLE_W-1:0] idle_q, idle_d;

    assign start_refresh_s = (idle_q == IDLE_W'(REFRESH - 1));

    // Consecutive IDLE cycles without a transaction; cleared by any transaction.
    always_comb begin
        idle_d = '0;
        if ((state_q == S_IDLE) && (state_d == S_IDLE)) begin
            idle_d = idle_q + IDLE_W'(1);
        end else begin
            idle_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign start_refresh_s = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        ack_d     = '0;
        refresh_d = refresh_q;
        case (state_q)
            S_IDLE: begin
                if (en && (req != '0)) begin
                    state_d   = S_ARM;
                    sel_d     = rr_pick(req, ptr_q);
                    refresh_d = 1'b0;
                end else if (start_refresh_s) begin
                    state_d   = S_ARM;
                    refresh_d = 1'b1;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_ARM: begin
                state_d = S_WAIT;
                cnt_d   = CNT_W'(CAPTURE_LAT - 1);
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = CNT_W'(HOLD - 1);
                    if (!refresh_q) begin
                        ack_d[sel_q] = 1'b1;
                    end else begin
                        ack_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    // Refresh captures leave the fairness pointer untouched.
                    if (!refresh_q) begin
                        ptr_d = (sel_q == SEL_BITS'(N_REQ - 1)) ? '0 : sel_q + SEL_BITS'(1);
                    end else begin
                        ptr_d = ptr_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        sh_sync_d = (state_d == S_ARM);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            ack_q     <= '0;
            sh_sync_q <= 1'b0;
            busy_q    <= 1'b0;
            refresh_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            sh_sync_q <= sh_sync_d;
            busy_q    <= busy_d;
            refresh_q <= refresh_d;
        end
    end

    assign ack     = ack_q;
    assign sh_sync = sh_sync_q;
    assign sel     = sel_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_sample_hold_sched.sv
// Self-checking bench for sample_hold_sched: transaction-timeline reference model plus directed scenarios.
module tb_sample_hold_sched;
    localparam int N = 4, L = 2, H = 4, REF = 64;

    logic       clk = 1'b0;
    logic       rst_n, en;
    logic [3:0] req, ack;
    logic       sh_sync, busy;
    logic [1:0] sel;
    logic [7:0] obs, exp_v;

    int   n_tests, n_fail;
    int   cyc, m_ts, m_g, m_ptr, m_idle_start;
    logic m_refresh;

    always #5 clk = ~clk;
    assign obs = {ack, sh_sync, sel, busy};

    sample_hold_sched dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .ack(ack), .sh_sync(sh_sync), .sel(sel), .busy(busy)
    );

    // Model: a transaction decided at ts has ARM at ts+1, ack at ts+2+L, IDLE again at ts+2+L+H.
    task automatic tick(input logic [3:0] r, input logic e);
        int idle_begin;
        @(negedge clk);
        req = r;
        en  = e;
        exp_v = {((cyc == m_ts + 2 + L) && !m_refresh) ? (4'b0001 << m_g) : 4'b0000,
                 (cyc == m_ts + 1), 2'(m_g),
                 ((cyc >= m_ts + 1) && (cyc <= m_ts + 1 + L + H))};
        idle_begin = (m_ts + 2 + L + H > m_idle_start) ? m_ts + 2 + L + H : m_idle_start;
        if (cyc >= m_ts + 2 + L + H) begin
            if (e && (r != 4'b0000)) begin
                for (int k = 0; k < N; k++) begin
                    if (r[(m_ptr + k) % N]) begin
                        m_g = (m_ptr + k) % N;
                        break;
                    end
                end
                m_ptr     = (m_g + 1) % N;
                m_ts      = cyc;
                m_refresh = 1'b0;
            end
`ifdef SAMPLE_HOLD_SCHED_AUTO_EN
            else if (cyc - idle_begin == REF - 1) begin
                m_ts      = cyc;
                m_refresh = 1'b1;
            end
`endif
        end
        cyc++;
    endtask

    task automatic model_init();
        m_ts = -1000; m_g = 0; m_ptr = 0; m_refresh = 1'b0;
        m_idle_start = cyc;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0; req = 4'b0000; en = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
        model_init();
    endtask

    function automatic int idx_of(input logic [3:0] a);
        for (int k = 0; k < 4; k++) if (a[k]) return k;
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; req = 4'b0000; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== 8'h00) begin n_fail++; $display("FAIL reset got %b want %b", obs, 8'h00); end
        end
        rst_n = 1'b1;
        model_init();
    endtask

    task automatic test_single();
        int t, ack_c;
        logic [3:0] r;
        r = 4'b0100; ack_c = -1;
        t = cyc;
        tick(r, 1'b1);
        for (int i = 1; i < 12; i++) begin
            tick(r, 1'b1);
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL single c%0d got %b want %b", cyc - 1, obs, exp_v); end
            if (ack !== 4'b0000) begin ack_c = cyc - 1; r = 4'b0000; end
        end
        n_tests++;
        if (ack_c != t + 4) begin n_fail++; $display("FAIL single_ack_time got %0d want %0d", ack_c, t + 4); end
    endtask

    task automatic test_fairness();
        logic [3:0] r, last;
        int order[4], times[4];
        int n;
        do_reset(2);
        r = 4'b1111; last = 4'b0000; n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            r = r & ~last; last = 4'b0000;
            tick(r, 1'b1);
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL fair c%0d got %b want %b", cyc - 1, obs, exp_v); end
            if (ack !== 4'b0000) begin order[n] = idx_of(ack); times[n] = cyc - 1; n++; last = ack; end
        end
        n_tests++;
        if (n != 4) begin n_fail++; $display("FAIL fair_timeout got %0d acks want 4", n); end
        for (int k = 0; k < n; k++) begin
            n_tests++;
            if (order[k] != k) begin n_fail++; $display("FAIL fair_order[%0d] got %0d want %0d", k, order[k], k); end
            if (k > 0) begin
                n_tests++;
                if (times[k] - times[k-1] != 8) begin
                    n_fail++; $display("FAIL fair_spacing[%0d] got %0d want 8", k, times[k] - times[k-1]);
                end
            end
        end
        n = -1;
        for (int i = 0; i < 12 && n < 0; i++) begin
            tick(4'b1111, 1'b1);
            if (ack !== 4'b0000) n = idx_of(ack);
        end
        n_tests++;
        if (n != 0) begin n_fail++; $display("FAIL fair_wrap got %0d want 0", n); end
    endtask

    task automatic test_rotation();
        int order[4];
        int n;
        do_reset(2);
        n = 0;
        for (int i = 0; i < 50 && n < 4; i++) begin
            tick(4'b1001, 1'b1);
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL rot c%0d got %b want %b", cyc - 1, obs, exp_v); end
            if (ack !== 4'b0000) begin order[n] = idx_of(ack); n++; end
        end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (k >= n || order[k] != ((k % 2 == 0) ? 0 : 3)) begin
                n_fail++; $display("FAIL rot_order[%0d] got %0d want %0d", k, (k < n) ? order[k] : -1, (k % 2 == 0) ? 0 : 3);
            end
        end
    endtask

    task automatic test_mid_drop();
        int acks, late_sh;
        do_reset(2);
        acks = 0; late_sh = 0;
        tick(4'b0010, 1'b1);
        tick(4'b0010, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick(4'b0000, 1'b0);
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL drop c%0d got %b want %b", cyc - 1, obs, exp_v); end
            if (ack === 4'b0010) acks++;
            if (sh_sync === 1'b1) late_sh++;
        end
        n_tests++;
        if (acks != 1 || late_sh != 0) begin
            n_fail++; $display("FAIL drop_summary got acks=%0d sh=%0d want acks=1 sh=0", acks, late_sh);
        end
    endtask

    task automatic test_reset_mid();
        int acks;
        for (int v = 0; v < 2; v++) begin
            do_reset(2);
            tick(4'b0100, 1'b1);
            repeat ((v == 0) ? 2 : 5) begin
                tick(4'b0100, 1'b1);
                n_tests++;
                if (obs !== exp_v) begin n_fail++; $display("FAIL rstmid c%0d got %b want %b", cyc - 1, obs, exp_v); end
            end
            rst_n = 1'b0; req = 4'b0000; en = 1'b0;
            #1;
            n_tests++;
            if (obs !== 8'h00) begin n_fail++; $display("FAIL rstmid_zero v%0d got %b want %b", v, obs, 8'h00); end
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            model_init();
            acks = 0;
            repeat (12) begin
                tick(4'b0000, 1'b0);
                n_tests++;
                if (obs !== exp_v) begin n_fail++; $display("FAIL rstmid_after c%0d got %b want %b", cyc - 1, obs, exp_v); end
                if (ack !== 4'b0000) acks++;
            end
            n_tests++;
            if (acks != 0) begin n_fail++; $display("FAIL rstmid_ack v%0d got %0d acks want 0", v, acks); end
        end
    endtask

    task automatic test_simultaneous();
        int t, sh2;
        do_reset(2);
        t = cyc; sh2 = -1;
        tick(4'b0001, 1'b1);
        for (int i = 1; i < 16; i++) begin
            tick((i < 4) ? 4'b0001 : 4'b0110, 1'b1);
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL simul c%0d got %b want %b", cyc - 1, obs, exp_v); end
            if (i > 1 && sh_sync === 1'b1 && sh2 < 0) sh2 = cyc - 1;
        end
        n_tests++;
        if (sh2 != t + 9) begin n_fail++; $display("FAIL simul_next_sh got %0d want %0d", sh2, t + 9); end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic e;
        do_reset(3);
        for (int i = 0; i < 400; i++) begin
            r = 4'($urandom_range(0, 15));
            e = ($urandom_range(0, 3) != 0);
            tick(r, e);
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL rand c%0d got %b want %b", cyc - 1, obs, exp_v); end
            n_tests++;
            if ((sh_sync === 1'b1 && ack !== 4'b0000) || $countones(ack) > 1) begin
                n_fail++; $display("FAIL rand_excl c%0d got ack=%b sh=%b", cyc - 1, ack, sh_sync);
            end
        end
    endtask

`ifdef SAMPLE_HOLD_SCHED_AUTO_EN
    task automatic test_refresh();
        int last_sh, d, ack_c;
        logic [3:0] r;
        do_reset(2);
        last_sh = -1;
        for (int i = 0; i < 220; i++) begin
            tick(4'b0000, 1'b0);
            n_tests++;
            if (obs !== exp_v || ack !== 4'b0000) begin
                n_fail++; $display("FAIL refresh c%0d got %b want %b", cyc - 1, obs, exp_v);
            end
            if (sh_sync === 1'b1) begin
                if (last_sh >= 0) begin
                    n_tests++;
                    if (cyc - 1 - last_sh != 71) begin
                        n_fail++; $display("FAIL refresh_period got %0d want 71", cyc - 1 - last_sh);
                    end
                end
                last_sh = cyc - 1;
            end
        end
        do_reset(2);
        while (cyc != m_idle_start + REF - 1) tick(4'b0000, 1'b0);
        d = cyc; r = 4'b0001; ack_c = -1;
        tick(r, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(r, 1'b1);
            n_tests++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL defer c%0d got %b want %b", cyc - 1, obs, exp_v); end
            if (ack === 4'b0001) begin ack_c = cyc - 1; r = 4'b0000; end
        end
        n_tests++;
        if (ack_c != d + 4) begin n_fail++; $display("FAIL defer_ack got %0d want %0d", ack_c, d + 4); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        req = 4'b0000; en = 1'b0; rst_n = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_rotation();
        test_mid_drop();
        test_reset_mid();
        test_simultaneous();
        test_random();
`ifdef SAMPLE_HOLD_SCHED_AUTO_EN
        test_refresh();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sample_hold_sched.md
# sample_hold_sched

Round-robin scheduler that shares one sample-and-hold capture stage between N_REQ requesters. It issues the one-cycle sync pulse that makes the sample-and-hold latch its input and drives the input mux select. It waits out the stage's capture latency, then acknowledges the winning requester while the held value is guaranteed stable. It sits between the per-channel snapshot/readout logic and the shared `sample_and_hold` + input mux in the general library datapath.

## Interface
- N_REQ, 4, number of requesters (2..16)
- SEL_BITS, log2(N_REQ) (derived localparam, min 1), mux select width
- CAPTURE_LAT, 2, cycles from sh_sync high to held value valid at sample-and-hold output (>=1)
- HOLD, 4, cycles the grant and select stay stable after capture (>=1)
- REFRESH, 64, idle cycles before an autonomous refresh capture (only with SAMPLE_HOLD_SCHED_AUTO_EN; >=2)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  enables new grants; sampled only in IDLE
- req  input  N_REQ  request per requester, level; held until ack
- ack  output  N_REQ  one-cycle, one-hot pulse: held value for that requester is valid
- sh_sync  output  1  one-cycle sync pulse to the sample-and-hold
- sel  output  SEL_BITS  mux select of the granted requester
- busy  output  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ARM, WAIT, HOLD. All outputs are registered.
- IDLE: if en=1 and req!=0, pick a winner g by round-robin; go to ARM, load sel<=g.
  - The round-robin search starts at ptr, so the first set bit at or above ptr wins, wrapping mod N_REQ.
- ARM: exactly one cycle; sh_sync=1. A counter loads CAPTURE_LAT-1. Next state is WAIT.
- WAIT: CAPTURE_LAT cycles; sh_sync=0. When the counter reaches 0, load HOLD-1 and go to HOLD.
- HOLD: HOLD cycles. ack[g]=1 on the first HOLD cycle only. When the counter reaches 0, go to IDLE and set ptr<=(g+1) mod N_REQ.
- Counter width is log2(max(CAPTURE_LAT,HOLD)+1). The counter only decrements; it never wraps.
- sel is stable from ARM entry through the last HOLD cycle, then retains its value in IDLE.
- req deasserted mid-transaction: the transaction completes and ack[g] still pulses.
- en deasserted mid-transaction: the transaction completes; no new grant is issued.
- req is ignored outside IDLE, and new requests are never preempted. A requester that keeps req high after its ack is re-arbitrated with lowest priority.
- Reset (any time, including mid-transaction): state=IDLE, sel=0, sh_sync=0, ack=0, busy=0, ptr=0, counters=0, effective immediately.

## Timing
- IDLE decision at cycle t gives: sh_sync high at t+1, WAIT t+2..t+1+CAPTURE_LAT, ack at t+2+CAPTURE_LAT.
- busy covers t+1..t+1+CAPTURE_LAT+HOLD; IDLE is back at t+2+CAPTURE_LAT+HOLD.
- Minimum grant spacing (back-to-back requests) = 2+CAPTURE_LAT+HOLD cycles; 8 at defaults.
- Request to ack latency with an idle scheduler: 2+CAPTURE_LAT cycles (req sampled at t).
- ack and sh_sync are never high in the same cycle. At most one ack bit is set.

## Configuration
- Macro: SAMPLE_HOLD_SCHED_AUTO_EN.
- Defined:
  - An idle counter counts consecutive IDLE cycles with no grant taken.
  - On reaching REFRESH-1, the scheduler runs a refresh transaction: ARM/WAIT/HOLD with sel unchanged, sh_sync pulsed, busy high, no ack, ptr unchanged.
  - The idle counter clears on any transaction and on reset.
  - If en=1 and req!=0 at the same cycle the counter hits REFRESH-1, the request wins and the refresh is deferred.
  - Refresh ignores en.
- Undefined: no idle counter; sh_sync is issued only for granted requests.

## Test plan
- Reset then single request: hold rst_n=0 5 cycles, then req=4'b0100 at t. Require sh_sync=1 at t+1, sel=2 from t+1, ack=4'b0100 only at t+4, busy t+1..t+7, IDLE at t+8.
- Round-robin fairness: req=4'b1111 held, each req bit dropped the cycle after its ack. Require grant order 0,1,2,3, acks spaced 8 cycles, ptr wraps to 0.
- Rotation and wrap: req=4'b1001 continuously. Require grants alternating 0,3,0,3.
- Mid-operation events:
  - Drop req and en during WAIT: the transaction still acks, then no further sh_sync.
  - Assert rst_n=0 during HOLD: all outputs 0 on the next sample, ack never fires.
- Simultaneous request: req changes in the same cycle as an ack. The new request is not granted before IDLE.
- SAMPLE_HOLD_SCHED_AUTO_EN (REFRESH=64):
  - No requests: sh_sync every 64+1+CAPTURE_LAT+HOLD=71 cycles, with ack always 0.
  - req=4'b0001 arriving at the refresh cycle: granted with an ack, refresh deferred.
